// File: rtl/spi_regbank_burst.sv
`default_nettype none
// ============================================================================
// Module   : spi_regbank_burst
// Brief    : SPI slave register bank with per-transaction SPI mode, burst
//            access with address auto-increment, write strobe and a sticky
//            access-error flag. All SPI inputs are already synchronous to clk.
// Revision : 1.0 - initial release
// ============================================================================
module spi_regbank_burst #(
    parameter int NUM_CFG    = 8,
    parameter int NUM_STATUS = 8,
    parameter int REG_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rstb,
    input  logic                            ena,
    input  logic [1:0]                      mode,
    input  logic                            spi_cs_n,
    input  logic                            spi_clk,
    input  logic                            spi_mosi,
    output logic                            spi_miso,
    output logic [NUM_CFG*REG_WIDTH-1:0]    config_regs,
    input  logic [NUM_STATUS*REG_WIDTH-1:0] status_regs,
    output logic                            wr_pulse,
    output logic [6:0]                      wr_addr,
    output logic                            err
);

    localparam int                 c_cnt_w     = $clog2(REG_WIDTH);
    localparam logic [c_cnt_w-1:0] c_cmd_last  = c_cnt_w'(7);
    localparam logic [c_cnt_w-1:0] c_word_last = c_cnt_w'(REG_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [7:0]         c_cfg_end   = 8'(NUM_CFG);
    localparam logic [7:0]         c_map_end   = 8'(NUM_CFG + NUM_STATUS);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_cmd  = 2'd1;
    localparam logic [1:0] c_st_data = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]           state_q,     state_d;
    logic                 cs_n_dly_q,  cs_n_dly_d;
    logic                 sclk_dly_q,  sclk_dly_d;
    logic                 cpol_q,      cpol_d;
    logic                 cpha_q,      cpha_d;
    logic [c_cnt_w-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [6:0]           cmd_q,       cmd_d;
    logic [REG_WIDTH-2:0] rx_q,        rx_d;
    logic [REG_WIDTH-1:0] tx_q,        tx_d;
    logic                 is_wr_q,     is_wr_d;
    logic [6:0]           addr_q,      addr_d;
    logic [REG_WIDTH-1:0] cfg_q [NUM_CFG];
    logic [REG_WIDTH-1:0] cfg_d [NUM_CFG];
    logic                 miso_q,      miso_d;
    logic                 wr_pulse_q,  wr_pulse_d;
    logic [6:0]           wr_addr_q,   wr_addr_d;
    logic                 err_q,       err_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                 w_rise, w_fall, w_lead, w_trail;
    logic                 w_sample, w_drive;
    logic                 w_cs_fall, w_cs_rise;
    logic [7:0]           w_cmd_word;
    logic [REG_WIDTH-1:0] w_word;
    logic [6:0]           w_addr_inc;
    logic                 w_wr_cfg;
    logic [6:0]           w_fetch_addr;
    logic [REG_WIDTH-1:0] w_fetch_data;
    logic                 w_fetch_unmapped;

    // Edge classification: leading/trailing depend on the mode latched at CS fall
    always_comb begin
        w_rise     = spi_clk & ~sclk_dly_q;
        w_fall     = ~spi_clk & sclk_dly_q;
        w_lead     = cpol_q ? w_fall : w_rise;
        w_trail    = cpol_q ? w_rise : w_fall;
        w_sample   = cpha_q ? w_trail : w_lead;
        w_drive    = cpha_q ? w_lead : w_trail;
        w_cs_fall  = cs_n_dly_q & ~spi_cs_n;
        w_cs_rise  = ~cs_n_dly_q & spi_cs_n;
        w_cmd_word = {cmd_q, spi_mosi};
        w_word     = {rx_q, spi_mosi};
        w_addr_inc = addr_q + 7'd1;
        w_wr_cfg   = ({1'b0, addr_q} < c_cfg_end);
    end

    // Read fetch: command address on the first word, next address on later words
    always_comb begin
        w_fetch_addr = (state_q == c_st_cmd) ? w_cmd_word[6:0] : w_addr_inc;
        w_fetch_data = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            if (w_fetch_addr == 7'(i)) begin
                w_fetch_data = cfg_q[i];
            end
        end
        for (int i = 0; i < NUM_STATUS; i++) begin
            if ({1'b0, w_fetch_addr} == 8'(NUM_CFG + i)) begin
                w_fetch_data = status_regs[i*REG_WIDTH +: REG_WIDTH];
            end
        end
        w_fetch_unmapped = ({1'b0, w_fetch_addr} >= c_map_end);
    end

    // Next-state logic: CS edges take priority over any SPI clock edge
    always_comb begin
        state_d    = state_q;
        cs_n_dly_d = spi_cs_n;
        sclk_dly_d = spi_clk;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_d      = cmd_q;
        rx_d       = rx_q;
        tx_d       = tx_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        cfg_d      = cfg_q;
        miso_d     = miso_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        err_d      = err_q;

        if (!ena) begin
            cs_n_dly_d = cs_n_dly_q;
            sclk_dly_d = sclk_dly_q;
            wr_pulse_d = wr_pulse_q;
        end else if (w_cs_rise) begin
            // Any partially shifted word is simply abandoned here
            state_d   = c_st_idle;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else if (w_cs_fall) begin
            state_d   = c_st_cmd;
            cpol_d    = mode[1];
            cpha_d    = mode[0];
            bit_cnt_d = '0;
            tx_d      = '0;
            miso_d    = 1'b0;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                c_st_cmd: begin
                    if (w_sample) begin
                        cmd_d = w_cmd_word[6:0];
                        if (bit_cnt_q == c_cmd_last) begin
                            state_d   = c_st_data;
                            bit_cnt_d = '0;
                            addr_d    = w_cmd_word[6:0];
                            is_wr_d   = w_cmd_word[7];
                            if (w_cmd_word[7]) begin
                                tx_d = '0;
                            end else begin
                                tx_d = w_fetch_data;
                                if (w_fetch_unmapped) begin
                                    err_d = 1'b1;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + c_cnt_one;
                        end
                    end
                end
                c_st_data: begin
                    if (w_drive) begin
                        miso_d = tx_q[REG_WIDTH-1];
                        tx_d   = {tx_q[REG_WIDTH-2:0], 1'b0};
                    end
                    if (w_sample) begin
                        rx_d = w_word[REG_WIDTH-2:0];
                        if (bit_cnt_q == c_word_last) begin
                            bit_cnt_d = '0;
                            addr_d    = w_addr_inc;
                            if (is_wr_q) begin
                                if (w_wr_cfg) begin
                                    for (int i = 0; i < NUM_CFG; i++) begin
                                        if (addr_q == 7'(i)) begin
                                            cfg_d[i] = w_word;
                                        end
                                    end
                                    wr_pulse_d = 1'b1;
                                    wr_addr_d  = addr_q;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end else begin
                                // Next word is ready well before the next drive edge
                                tx_d = w_fetch_data;
                                if (w_fetch_unmapped) begin
                                    err_d = 1'b1;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + c_cnt_one;
                        end
                    end
                end
                default: begin
                    state_d = c_st_idle;
                end
            endcase
        end
    end

    // State registers; CS history resets low so a CS held low through reset is not a new frame
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= c_st_idle;
            cs_n_dly_q <= 1'b0;
            sclk_dly_q <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            bit_cnt_q  <= '0;
            cmd_q      <= '0;
            rx_q       <= '0;
            tx_q       <= '0;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            cfg_q      <= '{default: '0};
            miso_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cs_n_dly_q <= cs_n_dly_d;
            sclk_dly_q <= sclk_dly_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            bit_cnt_q  <= bit_cnt_d;
            cmd_q      <= cmd_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            cfg_q      <= cfg_d;
            miso_q     <= miso_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            err_q      <= err_d;
        end
    end

    // Pack config registers onto the flat output bus
    generate
        for (genvar n = 0; n < NUM_CFG; n++) begin : g_cfg_pack
            assign config_regs[n*REG_WIDTH +: REG_WIDTH] = cfg_q[n];
        end
    endgenerate

    assign spi_miso = miso_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign err      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_regbank_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_regbank_burst
// Brief    : Directed bench for spi_regbank_burst (8-bit and 16-bit builds
//            sharing one SPI bus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_regbank_burst;

    localparam int H = 5;

    logic         clk = 1'b0;
    logic         rstb = 1'b0;
    logic         ena = 1'b1;
    logic [1:0]   mode = 2'b00;
    logic         cs_n = 1'b1;
    logic         sclk = 1'b0;
    logic         mosi = 1'b0;
    logic         miso8, miso16;
    logic [63:0]  cfg8;
    logic [127:0] cfg16;
    logic [63:0]  status8 = 64'h0000_0000_0000_10CA;
    logic [127:0] status16 = '0;
    logic         wr_pulse8, wr_pulse16;
    logic [6:0]   wr_addr8, wr_addr16;
    logic         err8, err16;

    int total = 0;
    int bad = 0;
    int pulses8 = 0;
    int p0;
    logic [63:0] rx8, rx16;

    spi_regbank_burst u_dut8 (
        .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .spi_cs_n(cs_n),
        .spi_clk(sclk), .spi_mosi(mosi), .spi_miso(miso8), .config_regs(cfg8),
        .status_regs(status8), .wr_pulse(wr_pulse8), .wr_addr(wr_addr8), .err(err8)
    );

    spi_regbank_burst #(.NUM_CFG(8), .NUM_STATUS(8), .REG_WIDTH(16)) u_dut16 (
        .clk(clk), .rstb(rstb), .ena(ena), .mode(mode), .spi_cs_n(cs_n),
        .spi_clk(sclk), .spi_mosi(mosi), .spi_miso(miso16), .config_regs(cfg16),
        .status_regs(status16), .wr_pulse(wr_pulse16), .wr_addr(wr_addr16), .err(err16)
    );

    always #5 clk = ~clk;

    // Count every cycle the 8-bit build holds its write strobe
    always @(posedge clk) begin
        if (wr_pulse8 === 1'b1) pulses8 <= pulses8 + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        sclk = m[1];
        repeat (H) @(negedge clk);
    endtask

    // One CS frame of nbits bits (MSB of the low nbits sent first); rst_at pulses rstb before that bit
    task automatic xfer(input int nbits, input logic [63:0] bits, input int rst_at,
                        output logic [63:0] r8, output logic [63:0] r16);
        logic cpol, cpha;
        cpol = mode[1];
        cpha = mode[0];
        r8 = '0;
        r16 = '0;
        @(negedge clk);
        cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int k = nbits - 1; k >= 0; k--) begin
            if (nbits - 1 - k == rst_at) begin
                rstb = 1'b0;
                repeat (2) @(negedge clk);
                rstb = 1'b1;
            end
            if (!cpha) begin
                mosi = bits[k];
                repeat (H) @(negedge clk);
                r8 = {r8[62:0], miso8};
                r16 = {r16[62:0], miso16};
                sclk = ~cpol;
                repeat (H) @(negedge clk);
                sclk = cpol;
            end else begin
                repeat (H) @(negedge clk);
                sclk = ~cpol;
                mosi = bits[k];
                repeat (H) @(negedge clk);
                r8 = {r8[62:0], miso8};
                r16 = {r16[62:0], miso16};
                sclk = cpol;
            end
        end
        repeat (H) @(negedge clk);
        cs_n = 1'b1;
        mosi = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_cfg", cfg8, 0);
        chk("rst_miso", miso8, 0);
        chk("rst_wr_pulse", wr_pulse8, 0);
        chk("rst_wr_addr", wr_addr8, 0);
        chk("rst_err", err8, 0);
        rstb = 1'b1;
        repeat (4) @(negedge clk);

        // Mode 0 single write 0x82, 0x3C
        set_mode(2'b00);
        p0 = pulses8;
        xfer(16, 64'h823C, -1, rx8, rx16);
        chk("m0_wr_cfg", cfg8, 64'h0000_0000_003C_0000);
        chk("m0_wr_pulses", pulses8 - p0, 1);
        chk("m0_wr_addr", wr_addr8, 7'd2);
        chk("m0_wr_err", err8, 0);

        // Mode 1 burst write 0x86 running into status space
        set_mode(2'b01);
        p0 = pulses8;
        xfer(32, 64'h8611_2233, -1, rx8, rx16);
        chk("m1_burst_cfg", cfg8, 64'h2211_0000_003C_0000);
        chk("m1_burst_pulses", pulses8 - p0, 2);
        chk("m1_burst_wr_addr", wr_addr8, 7'd7);
        chk("m1_burst_err", err8, 1);

        // Mode 3 burst read of status addresses 8, 9
        set_mode(2'b11);
        p0 = pulses8;
        xfer(24, 64'h08_0000, -1, rx8, rx16);
        chk("m3_rd_miso", rx8[23:0], 24'h00_CA10);
        chk("m3_rd_err", err8, 0);
        chk("m3_rd_pulses", pulses8 - p0, 0);

        // Mode 2 write aborted after 5 data bits
        set_mode(2'b10);
        p0 = pulses8;
        xfer(13, 64'h1035, -1, rx8, rx16);
        chk("m2_abort_cfg", cfg8, 64'h2211_0000_003C_0000);
        chk("m2_abort_pulses", pulses8 - p0, 0);

        // Clean follow-up frame after the abort
        set_mode(2'b00);
        p0 = pulses8;
        xfer(16, 64'h815A, -1, rx8, rx16);
        chk("post_abort_cfg", cfg8, 64'h2211_0000_003C_5A00);
        chk("post_abort_pulses", pulses8 - p0, 1);
        chk("post_abort_wr_addr", wr_addr8, 7'd1);
        chk("post_abort_err", err8, 0);

        // 16-bit build: read of unmapped address 0x7F
        xfer(24, 64'h7F_0000, -1, rx8, rx16);
        chk("w16_rd_miso", rx16[15:0], 16'h0000);
        chk("w16_rd_err", err16, 1);
        @(negedge clk);
        cs_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("w16_err_clear", err16, 0);
        cs_n = 1'b1;
        repeat (H) @(negedge clk);

        // Reset pulsed during the second word of a burst write at address 3
        xfer(24, 64'h83_5566, 19, rx8, rx16);
        chk("midrst_cfg", cfg8, 0);
        chk("midrst_miso", miso8, 0);
        chk("midrst_err", err8, 0);
        chk("midrst_wr_addr", wr_addr8, 0);
        p0 = pulses8;
        xfer(16, 64'h80A5, -1, rx8, rx16);
        chk("after_rst_cfg", cfg8, 64'h0000_0000_0000_00A5);
        chk("after_rst_pulses", pulses8 - p0, 1);
        chk("after_rst_wr_addr", wr_addr8, 0);

        // Read at 127 then wrap to 0
        xfer(24, 64'h7F_0000, -1, rx8, rx16);
        chk("wrap_rd_miso", rx8[15:0], 16'h00A5);
        chk("wrap_rd_err", err8, 1);

        // Clock enable low: a full write frame must leave everything untouched
        @(negedge clk);
        ena = 1'b0;
        p0 = pulses8;
        xfer(16, 64'h8011, -1, rx8, rx16);
        @(negedge clk);
        ena = 1'b1;
        repeat (H) @(negedge clk);
        chk("ena_off_cfg", cfg8, 64'h0000_0000_0000_00A5);
        chk("ena_off_pulses", pulses8 - p0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spi_regbank_burst.md
Name: spi_regbank_burst

Overview:
Parametrised SPI slave register bank, the next generation of the team's spi_wrapper. It supports independent config/status counts, configurable word width, all four SPI modes latched per transaction, and multi-word bursts with address auto-increment. It also adds a write strobe and a per-transaction access-error flag. It sits behind the existing 2-stage synchronizers in the top level; all SPI inputs arrive already synchronous to clk.

Parameters:
NUM_CFG, 8, number of read/write config registers (addresses 0..NUM_CFG-1)
NUM_STATUS, 8, number of read-only status registers (addresses NUM_CFG..NUM_CFG+NUM_STATUS-1); NUM_CFG+NUM_STATUS <= 128
REG_WIDTH, 8, bits per register/data word; legal values 8, 16, 32

Ports:
clk  in  1  system clock
rstb  in  1  asynchronous active-low reset
ena  in  1  clock enable; 0 freezes all state (no capture, outputs hold)
mode  in  2  {cpol,cpha}, synchronised; latched at CS assertion
spi_cs_n  in  1  chip select, active low, synchronised
spi_clk  in  1  SPI clock, synchronised; must be <= clk/8
spi_mosi  in  1  serial data in, synchronised
spi_miso  out  1  serial data out, MSB first
config_regs  out  NUM_CFG*REG_WIDTH  config register contents, reg n at [n*REG_WIDTH +: REG_WIDTH]
status_regs  in  NUM_STATUS*REG_WIDTH  status register inputs, same packing
wr_pulse  out  1  one-cycle strobe on each committed config write
wr_addr  out  7  address of the last committed write
err  out  1  sticky access error for the current/last transaction

Behaviour:
- Reset: config_regs=0, spi_miso=0, wr_pulse=0, wr_addr=0, err=0, FSM=IDLE, shift/bit counters=0.
- Edge detect: spi_clk_d register; rise = spi_clk&~spi_clk_d, fall = ~spi_clk&spi_clk_d. At CS falling edge spi_clk_d is loaded with spi_clk, so there is no false edge.
- Latched mode (cpol_l, cpha_l) is captured on the CS falling edge. Mode pin changes mid-transaction are ignored.
- Leading edge = transition away from cpol_l; trailing = the opposite transition.
- cpha_l=0: sample MOSI on leading edge, drive MISO on trailing edge.
- cpha_l=1: drive on leading edge, sample on trailing edge.
- FSM:
  - IDLE -> CMD on CS falling.
  - CMD: shift 8 sampled bits; bit7=1 means write, 0 means read; bits[6:0]=start address. On the 8th sample -> DATA, addr_ptr=cmd addr. On a read, fetch the word at addr_ptr into the tx shifter.
  - DATA: REG_WIDTH bits per word, MSB first.
    - Write word complete: the word commits one clk after the detection cycle of the last sample. addr_ptr increments (mod 128). The next word starts immediately.
    - Read: on word completion addr_ptr increments and the next word is loaded into the tx shifter before the next drive edge.
  - Any state -> IDLE on CS rising. A partially received word is discarded (no write, no strobe).
- Write decode:
  - addr < NUM_CFG: update reg, wr_pulse=1 for exactly one clk, wr_addr=addr.
  - Status or unmapped address: no change, no strobe, err=1.
- Read decode: config or status value. Unmapped addresses read 0 and set err=1.
- err clears on CS falling edge; it is otherwise sticky until the next transaction.
- MISO:
  - 0 in IDLE and CMD.
  - In DATA it presents the current tx bit. The first data MSB is valid after the first drive edge following the 8th command sample.
  - With cpha_l=0 there is one drive edge between command bit 8 and data bit 1. The fetch must complete within 2 clks of the last command sample.
- Address increments past 127 wrap to 0.
- Simultaneous CS rise and sample edge in the same clk: CS wins; the sample is dropped.
- Reset asserted mid-transaction: immediate return to reset values; the next transaction requires a fresh CS falling edge.

Test Plan:
- Mode 0, write cmd 0x82 + data 0x3C -> config reg2=0x3C one clk after the last sample; wr_pulse high 1 cycle; wr_addr=2; err=0.
- Mode 1, burst write cmd 0x86 + 0x11,0x22,0x33 (NUM_CFG=8) -> reg6=0x11, reg7=0x22, addr8 unchanged; 2 wr_pulses; err=1.
- Mode 3, burst read cmd 0x08 with status {0xCA,0x10} at addr 8,9 -> MISO returns 0xCA then 0x10 MSB first; err=0; no wr_pulse.
- Mode 2, write cmd 0x81 then CS deasserted after 5 data bits -> reg1 unchanged; no wr_pulse. The next transaction starts cleanly.
- REG_WIDTH=16: read cmd 0x7F (unmapped) -> MISO 0x0000, err=1. A new CS assertion clears err.
- rstb pulsed mid-burst write after word 1 -> all config_regs=0, MISO=0. A following mode 0 write cmd 0x80 + 0xA5 writes reg0=0xA5.
